// File: rtl/obstacle_sweep.sv
// obstacle_sweep
//   Draws N_RECT vertically bouncing rectangles inside the play area once it
//   is armed by the selector handshake. It overlays COLOR on the pixel stream,
//   reports hit-pixel coordinates, and pulses done when the run completes.
//
// Ports:
//   pclk, rst        pixel clock, synchronous active-high reset
//   hcount_in        horizontal pixel counter
//   vcount_in        vertical line counter
//   rgb_in           upstream pixel colour
//   play_selected    game running
//   menu_on          menu active; aborts the run
//   selected         selector code of the obstacle to run
//   done_in          previous obstacle finished; arms the selection
//   working          high while drawing
//   done             one-cycle pulse at normal completion
//   rgb_out          pixel colour to downstream (1 pclk latency)
//   obstacle_x/y     coordinates of a hit pixel, else 0
//
// Optional feature macro: OBSTACLE_SWEEP_ACCEL_EN
//   When defined, the speed starts at SPEED and grows by 1 every 60 frame
//   ticks, saturating at 2*SPEED. When undefined, the speed is constant SPEED.
module obstacle_sweep #(
    parameter int          N_RECT          = 2,
    parameter int          RECT_W          = 64,
    parameter int          RECT_H          = 32,
    parameter int          X_START         = 340,
    parameter int          X_PITCH         = 128,
    parameter int          AREA_TOP        = 234,
    parameter int          AREA_BOTTOM     = 534,
    parameter int          SPEED           = 2,
    parameter int          DURATION_FRAMES = 180,
    parameter int          TICK_LINE       = 768,
    parameter logic [11:0] COLOR           = 12'hfff,
    parameter logic [3:0]  SELECT_CODE     = 4'b0001
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic [11:0] rgb_in,
    input  logic        play_selected,
    input  logic        menu_on,
    input  logic [3:0]  selected,
    input  logic        done_in,
    output logic        working,
    output logic        done,
    output logic [11:0] rgb_out,
    output logic [11:0] obstacle_x,
    output logic [11:0] obstacle_y
);

    typedef enum logic {IDLE, DRAW} state_t;

    localparam logic [11:0] TOP_Y      = 12'(AREA_TOP);
    localparam logic [11:0] LOW_Y      = 12'(AREA_BOTTOM - RECT_H);
    localparam logic [11:0] BOTTOM_Y   = 12'(AREA_BOTTOM);
    localparam logic [11:0] H_W        = 12'(RECT_W);
    localparam logic [11:0] H_H        = 12'(RECT_H);
    localparam logic [11:0] TICK_V     = 12'(TICK_LINE);
    localparam logic [15:0] LAST_FRAME = 16'(DURATION_FRAMES - 1);

    state_t state, next_state;

    logic [11:0] y_pos  [N_RECT];
    logic [11:0] y_next [N_RECT];
    logic [N_RECT-1:0] dir_up, dir_up_next;
    logic [15:0] frame_cnt;
    logic [11:0] speed;

    logic tick, abort, arm, last_tick, hit;

    // Even rectangles start at the top moving down, odd ones at the bottom moving up.
    function automatic logic [11:0] init_y(input int i);
        return (i % 2 == 0) ? TOP_Y : LOW_Y;
    endfunction

    assign tick      = (hcount_in == 12'd0) && (vcount_in == TICK_V);
    assign abort     = menu_on || !play_selected;
    assign arm       = done_in && play_selected && (selected == SELECT_CODE);
    assign last_tick = tick && (frame_cnt == LAST_FRAME);

`ifdef OBSTACLE_SWEEP_ACCEL_EN
    localparam logic [11:0] BASE_SPEED = 12'(SPEED);
    localparam logic [11:0] MAX_SPEED  = 12'(2 * SPEED);
    logic [5:0] accel_cnt;

    // The speed used by the current tick is the value before this tick's increment.
    always_ff @(posedge pclk) begin
        if (rst || (state == IDLE && arm)) begin
            speed     <= BASE_SPEED;
            accel_cnt <= 6'd0;
        end else if (state == DRAW && tick) begin
            if (accel_cnt == 6'd59) begin
                accel_cnt <= 6'd0;
                if (speed < MAX_SPEED) speed <= speed + 12'd1;
            end else begin
                accel_cnt <= accel_cnt + 6'd1;
            end
        end
    end
`else
    assign speed = 12'(SPEED);
`endif

    always_ff @(posedge pclk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Abort takes priority over completion so a simultaneous abort never pulses done.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (arm) next_state = DRAW;
            DRAW: if (abort || last_tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Overlapping rectangles simply OR into one hit.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N_RECT; i++) begin
            if (hcount_in >= 12'(X_START + i * X_PITCH) &&
                hcount_in <  12'(X_START + i * X_PITCH) + H_W &&
                vcount_in >= y_pos[i] && vcount_in < y_pos[i] + H_H)
                hit = 1'b1;
        end
    end

    // Bounce with clamping so positions never step outside the area.
    always_comb begin
        for (int i = 0; i < N_RECT; i++) begin
            y_next[i]      = y_pos[i];
            dir_up_next[i] = dir_up[i];
            if (!dir_up[i]) begin
                if (y_pos[i] + H_H + speed >= BOTTOM_Y) begin
                    y_next[i]      = LOW_Y;
                    dir_up_next[i] = 1'b1;
                end else begin
                    y_next[i] = y_pos[i] + speed;
                end
            end else begin
                if (y_pos[i] < TOP_Y + speed) begin
                    y_next[i]      = TOP_Y;
                    dir_up_next[i] = 1'b0;
                end else begin
                    y_next[i] = y_pos[i] - speed;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst || (state == IDLE && arm)) begin
            for (int i = 0; i < N_RECT; i++) begin
                y_pos[i]  <= init_y(i);
                dir_up[i] <= (i % 2 == 1);
            end
            frame_cnt <= 16'd0;
        end else if (state == DRAW && tick) begin
            for (int i = 0; i < N_RECT; i++) begin
                y_pos[i]  <= y_next[i];
                dir_up[i] <= dir_up_next[i];
            end
            frame_cnt <= last_tick ? 16'd0 : frame_cnt + 16'd1;
        end
    end

    // Outputs only show hits while staying in DRAW, so an abort or completion
    // cycle already passes the pixel stream through.
    always_ff @(posedge pclk) begin
        if (rst) begin
            working    <= 1'b0;
            done       <= 1'b0;
            rgb_out    <= 12'd0;
            obstacle_x <= 12'd0;
            obstacle_y <= 12'd0;
        end else begin
            working <= (next_state == DRAW);
            done    <= (state == DRAW) && !abort && last_tick;
            if (state == DRAW && next_state == DRAW && hit) begin
                rgb_out    <= COLOR;
                obstacle_x <= hcount_in;
                obstacle_y <= vcount_in;
            end else begin
                rgb_out    <= rgb_in;
                obstacle_x <= 12'd0;
                obstacle_y <= 12'd0;
            end
        end
    end

endmodule
